alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_seq_muldiv.sv | 94 +++++++++
 rtl/alu_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding, FSM states and constants for alu_seq
package alu_pkg;

    // Codes 25..31 are unassigned and report err_o. LUI passes b; ADDR computes a + imm.
    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_BEQ   = 5'd10,
        OP_BNE   = 5'd11,
        OP_BLT   = 5'd12,
        OP_BGE   = 5'd13,
        OP_BLTU  = 5'd14,
        OP_BGEU  = 5'd15,
        OP_LUI   = 5'd16,
        OP_ADDR  = 5'd17,
        OP_MUL   = 5'd18,
        OP_MULH  = 5'd19,
        OP_MULHU = 5'd20,
        OP_DIV   = 5'd21,
        OP_DIVU  = 5'd22,
        OP_REM   = 5'd23,
        OP_REMU  = 5'd24
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BR_OFFSET = 4;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - one-bit-per-cycle shift-add multiplier / restoring divider (ALU_SEQ_MULDIV_EN)
`ifdef ALU_SEQ_MULDIV_EN
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, a_q, a_d;
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d;

    logic            signed_op, a_neg, b_neg, ge;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   sum, sh;

    assign signed_op = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg     = signed_op && a_i[XLEN-1];
    assign b_neg     = signed_op && b_i[XLEN-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    assign sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign sh  = {hi_q, lo_q[XLEN-1]};
    assign ge  = sh >= {1'b0, opnd_q};

    // The final step's outcome is visible through the _d values, so done_o marks that edge.
    assign done_o = busy_q && (cnt_q == CW'(XLEN - 1));

    always_comb begin
        busy_d = busy_q; cnt_d = cnt_q; hi_d = hi_q; lo_d = lo_q; opnd_d = opnd_q;
        a_d = a_q; op_d = op_q; neg_d = neg_q; rneg_d = rneg_q; bz_d = bz_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            hi_d   = '0;
            op_d   = op_i;
            a_d    = a_i;
            neg_d  = a_neg ^ b_neg;
            rneg_d = a_neg;
            bz_d   = (b_i == '0);
            lo_d   = (op_i >= OP_DIV) ? a_mag : b_mag;
            opnd_d = (op_i >= OP_DIV) ? b_mag : a_mag;
        end else if (busy_q) begin
            if (op_q >= OP_DIV) begin
                hi_d = ge ? XLEN'(sh - {1'b0, opnd_q}) : sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], ge};
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_comb begin
        result_o = '0;
        case (op_q)
            OP_MUL:            result_o = lo_d;
            OP_MULH, OP_MULHU: result_o = XLEN'((neg_q ? -{hi_d, lo_d} : {hi_d, lo_d}) >> XLEN);
            OP_DIV, OP_DIVU:   result_o = bz_q ? '1 : (neg_q ? -lo_d : lo_d);
            OP_REM, OP_REMU:   result_o = bz_q ? a_q : (rneg_q ? -hi_d : hi_d);
            default:           result_o = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0; cnt_q <= '0; hi_q <= '0; lo_q <= '0; opnd_q <= '0;
            a_q <= '0; op_q <= '0; neg_q <= 1'b0; rneg_q <= 1'b0; bz_q <= 1'b0;
        end else begin
            busy_q <= busy_d; cnt_q <= cnt_d; hi_q <= hi_d; lo_q <= lo_d; opnd_q <= opnd_d;
            a_q <= a_d; op_q <= op_d; neg_q <= neg_d; rneg_q <= rneg_d; bz_q <= bz_d;
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with branch resolution; iterative mul/div under ALU_SEQ_MULDIV_EN
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] y_o,
    output logic            taken_o,
    output logic            err_o
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] y_q, y_d;
    logic            taken_q, taken_d, err_q, err_d;

    logic            accept, is_br, br_cond, alu_err;
    logic [XLEN-1:0] alu_y;
    logic [SHW-1:0]  shamt;

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign accept      = in_valid_i && in_ready_o;
    assign shamt       = b_i[SHW-1:0];
    assign y_o         = y_q;
    assign taken_o     = taken_q;
    assign err_o       = err_q;

`ifdef ALU_SEQ_MULDIV_EN
    logic            md_start, md_done;
    logic [XLEN-1:0] md_result;

    assign md_start = accept && is_muldiv(op_i);

    alu_seq_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .done_o   (md_done),
        .result_o (md_result)
    );
`endif

    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        is_br   = 1'b0;
        br_cond = 1'b0;
        case (op_i)
            OP_ADD:  alu_y = a_i + b_i;
            OP_SUB:  alu_y = a_i - b_i;
            OP_SLL:  alu_y = a_i << shamt;
            OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, a_i < b_i};
            OP_XOR:  alu_y = a_i ^ b_i;
            OP_SRL:  alu_y = a_i >> shamt;
            OP_SRA:  alu_y = $unsigned($signed(a_i) >>> shamt);
            OP_OR:   alu_y = a_i | b_i;
            OP_AND:  alu_y = a_i & b_i;
            OP_BEQ:  begin is_br = 1'b1; br_cond = (a_i == b_i); end
            OP_BNE:  begin is_br = 1'b1; br_cond = (a_i != b_i); end
            OP_BLT:  begin is_br = 1'b1; br_cond = $signed(a_i) < $signed(b_i); end
            OP_BGE:  begin is_br = 1'b1; br_cond = $signed(a_i) >= $signed(b_i); end
            OP_BLTU: begin is_br = 1'b1; br_cond = a_i < b_i; end
            OP_BGEU: begin is_br = 1'b1; br_cond = a_i >= b_i; end
            OP_LUI:  alu_y = b_i;
            OP_ADDR: alu_y = a_i + imm_i;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_y = '0;
`endif
            default: alu_err = 1'b1;
        endcase
        if (is_br) begin
            alu_y = br_cond ? (pc_i + imm_i) : (pc_i + XLEN'(BR_OFFSET));
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        taken_d = taken_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DONE;
                    y_d     = alu_y;
                    taken_d = is_br && br_cond;
                    err_d   = alu_err;
`ifdef ALU_SEQ_MULDIV_EN
                    if (md_start) state_d = ST_ITER;
`endif
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_ITER: begin
                if (md_done) begin
                    state_d = ST_DONE;
                    y_d     = md_result;
                end
            end
`endif
            ST_DONE: begin
                // Handshake edge only returns to IDLE; acceptance resumes the following cycle.
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

endmodule
